// File: rtl/i2c_slave_ctrl.sv
// I2C slave at a fixed 7-bit address, oversampled on clk, open-drain sda.
// Master writes stream out on rx_data/rx_valid; master reads are served from tx_data.
`timescale 1ns/1ps
module i2c_slave_ctrl #(
    parameter logic [6:0] ADDRESS = 7'h27
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    inout  logic       sda,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_load,
    output logic       rw,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_WR_DATA,
        S_WR_ACK,
        S_RD_DATA,
        S_RD_ACK,
        S_IGNORE
    } state_t;

    state_t     state_q, state_d;
    logic       sclk_meta_q, sclk_meta_d;
    logic       sclk_sync_q, sclk_sync_d;
    logic       sclk_prev_q, sclk_prev_d;
    logic       sda_meta_q, sda_meta_d;
    logic       sda_sync_q, sda_sync_d;
    logic       sda_prev_q, sda_prev_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       flag_q, flag_d;
    logic       oe_q, oe_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       tx_load_q, tx_load_d;
    logic       rw_q, rw_d;
    logic       busy_q, busy_d;

    logic sclk_rise, sclk_fall, start_cond, stop_cond;

    assign sclk_rise  = sclk_sync_q & ~sclk_prev_q;
    assign sclk_fall  = ~sclk_sync_q & sclk_prev_q;
    assign start_cond = sclk_sync_q & sclk_prev_q & sda_prev_q & ~sda_sync_q;
    assign stop_cond  = sclk_sync_q & sclk_prev_q & ~sda_prev_q & sda_sync_q;

    // flag_q: in the ACK states it marks "ACK already driven"; in RD_ACK it marks "master ACKed"
    always_comb begin
        sclk_meta_d = sclk;
        sclk_sync_d = sclk_meta_q;
        sclk_prev_d = sclk_sync_q;
        sda_meta_d  = sda;
        sda_sync_d  = sda_meta_q;
        sda_prev_d  = sda_sync_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        flag_d      = flag_q;
        oe_d        = oe_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        tx_load_d   = 1'b0;
        rw_d        = rw_q;
        busy_d      = busy_q;

        if (start_cond) begin
            state_d = S_ADDR;
            cnt_d   = 3'd0;
            flag_d  = 1'b0;
            oe_d    = 1'b0;
        end else if (stop_cond) begin
            state_d = S_IDLE;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                S_ADDR: begin
                    if (sclk_rise) begin
                        shift_d = {shift_q[6:0], sda_sync_q};
                        cnt_d   = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            if (shift_q[6:0] == ADDRESS) begin
                                rw_d    = sda_sync_q;
                                busy_d  = 1'b1;
                                flag_d  = 1'b0;
                                state_d = S_ADDR_ACK;
                            end else begin
                                state_d = S_IGNORE;
                            end
                        end
                    end
                end
                S_ADDR_ACK, S_WR_ACK: begin
                    if (sclk_fall) begin
                        if (!flag_q) begin
                            oe_d   = 1'b1;
                            flag_d = 1'b1;
                        end else if (state_q == S_WR_ACK || !rw_q) begin
                            oe_d    = 1'b0;
                            flag_d  = 1'b0;
                            cnt_d   = 3'd0;
                            state_d = S_WR_DATA;
                        end else begin
                            shift_d   = tx_data;
                            tx_load_d = 1'b1;
                            oe_d      = ~tx_data[7];
                            flag_d    = 1'b0;
                            cnt_d     = 3'd0;
                            state_d   = S_RD_DATA;
                        end
                    end
                end
                S_WR_DATA: begin
                    if (sclk_rise) begin
                        shift_d = {shift_q[6:0], sda_sync_q};
                        cnt_d   = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            rx_data_d  = {shift_q[6:0], sda_sync_q};
                            rx_valid_d = 1'b1;
                            flag_d     = 1'b0;
                            state_d    = S_WR_ACK;
                        end
                    end
                end
                S_RD_DATA: begin
                    if (sclk_fall) begin
                        if (cnt_q == 3'd7) begin
                            oe_d    = 1'b0;
                            flag_d  = 1'b0;
                            state_d = S_RD_ACK;
                        end else begin
                            shift_d = {shift_q[6:0], 1'b0};
                            oe_d    = ~shift_q[6];
                            cnt_d   = cnt_q + 3'd1;
                        end
                    end
                end
                S_RD_ACK: begin
                    if (sclk_rise) begin
                        if (!sda_sync_q) begin
                            flag_d = 1'b1;
                        end else begin
                            busy_d  = 1'b0;
                            state_d = S_IGNORE;
                        end
                    end else if (sclk_fall && flag_q) begin
                        shift_d   = tx_data;
                        tx_load_d = 1'b1;
                        oe_d      = ~tx_data[7];
                        flag_d    = 1'b0;
                        cnt_d     = 3'd0;
                        state_d   = S_RD_DATA;
                    end
                end
                default: begin
                    oe_d = 1'b0;
                end
            endcase
        end
    end

    // Synchronizers reset to the idle-bus level so leaving reset creates no false edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk_meta_q <= 1'b1;
            sclk_sync_q <= 1'b1;
            sclk_prev_q <= 1'b1;
            sda_meta_q  <= 1'b1;
            sda_sync_q  <= 1'b1;
            sda_prev_q  <= 1'b1;
            state_q     <= S_IDLE;
            cnt_q       <= 3'd0;
            shift_q     <= 8'h00;
            flag_q      <= 1'b0;
            oe_q        <= 1'b0;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            tx_load_q   <= 1'b0;
            rw_q        <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            sclk_meta_q <= sclk_meta_d;
            sclk_sync_q <= sclk_sync_d;
            sclk_prev_q <= sclk_prev_d;
            sda_meta_q  <= sda_meta_d;
            sda_sync_q  <= sda_sync_d;
            sda_prev_q  <= sda_prev_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            flag_q      <= flag_d;
            oe_q        <= oe_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            tx_load_q   <= tx_load_d;
            rw_q        <= rw_d;
            busy_q      <= busy_d;
        end
    end

    assign sda      = oe_q ? 1'b0 : 1'bz;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign tx_load  = tx_load_q;
    assign rw       = rw_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// Self-checking bench: a bus-level I2C master drives table, hand-written and random
// transactions; expectations come from the addressing/ACK rules applied per transaction.
`timescale 1ns/1ps
module tb_i2c_slave_ctrl;

    localparam int Q = 4;
    localparam logic [6:0] SLAVE_ADDR = 7'h27;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sclk = 1'b1;
    logic       m_low = 1'b0;
    wire        sda_bus;
    logic [7:0] rx_data;
    logic [7:0] tx_data;
    logic       rx_valid;
    logic       tx_load;
    logic       rw;
    logic       busy;

    pullup (sda_bus);
    assign sda_bus = m_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    i2c_slave_ctrl #(.ADDRESS(SLAVE_ADDR)) dut (
        .clk      (clk),
        .rst      (rst),
        .sclk     (sclk),
        .sda      (sda_bus),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_load  (tx_load),
        .rw       (rw),
        .busy     (busy)
    );

    int         checks = 0;
    int         failures = 0;
    int         rx_cnt = 0;
    int         load_count = 0;
    int         width_err = 0;
    int         drive_cnt = 0;
    int         load_base = 0;
    logic [7:0] rx_log [256];
    logic       rx_prev = 1'b0;
    logic       ld_prev = 1'b0;
    logic [7:0] tx_bytes [4];
    logic [1:0] tx_idx;

    logic       obs_addr_ack;
    logic       obs_busy_mid;
    logic       obs_ack [4];
    logic [7:0] obs_rd [4];
    logic       model_rw = 1'b0;
    logic [7:0] model_rx = 8'h00;

    // Local logic presents the next queued byte once the previous one has been loaded
    assign tx_idx  = 2'(load_count - load_base);
    assign tx_data = tx_bytes[tx_idx];

    always @(negedge clk) begin
        if (rx_valid) begin
            rx_log[rx_cnt[7:0]] = rx_data;
            rx_cnt++;
            if (rx_prev) width_err++;
        end
        if (tx_load) begin
            load_count++;
            if (ld_prev) width_err++;
        end
        if (sda_bus === 1'b0 && !m_low) drive_cnt++;
        rx_prev = rx_valid;
        ld_prev = tx_load;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic xfer_bit(input logic b, output logic s);
        m_low = ~b;
        wait_clks(Q);
        sclk = 1'b1;
        wait_clks(Q);
        s = sda_bus;
        wait_clks(Q);
        sclk = 1'b0;
        wait_clks(Q);
    endtask

    task automatic xfer_byte(input logic [7:0] b, output logic [7:0] got);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            xfer_bit(b[i], s);
            got[i] = s;
        end
    endtask

    task automatic bus_start();
        if (sclk == 1'b0) begin
            m_low = 1'b0;
            wait_clks(Q);
            sclk = 1'b1;
            wait_clks(Q);
        end
        m_low = 1'b1;
        wait_clks(Q);
        sclk = 1'b0;
        wait_clks(Q);
    endtask

    task automatic bus_stop();
        m_low = 1'b1;
        wait_clks(Q);
        sclk = 1'b1;
        wait_clks(2 * Q);
        m_low = 1'b0;
        wait_clks(2 * Q);
    endtask

    // Master side of one addressed transfer; reads ACK every byte but the last
    task automatic txn_body(input logic [6:0] addr, input logic r, input int n, input logic [31:0] data);
        logic [7:0] got;
        logic       s;
        xfer_byte({addr, r}, got);
        xfer_bit(1'b1, obs_addr_ack);
        obs_busy_mid = busy;
        for (int i = 0; i < n; i++) begin
            if (!r) begin
                xfer_byte(data[8*i +: 8], got);
                xfer_bit(1'b1, obs_ack[i]);
            end else begin
                xfer_byte(8'hFF, obs_rd[i]);
                xfer_bit(i == n - 1, s);
            end
        end
    endtask

    task automatic check_txn(input string tag, input logic [6:0] addr, input logic r, input int n,
                             input logic [31:0] data, input int rx_base, input int ld_base, input int drv_base);
        logic match;
        int   exp_rx;
        match = (addr == SLAVE_ADDR);
        checkOutput({tag, " addr_ack"}, 32'(obs_addr_ack), match ? 32'd0 : 32'd1);
        checkOutput({tag, " busy_mid"}, 32'(obs_busy_mid), 32'(match));
        for (int i = 0; i < n; i++) begin
            if (!r) checkOutput({tag, " data_ack"}, 32'(obs_ack[i]), match ? 32'd0 : 32'd1);
            else    checkOutput({tag, " read_byte"}, 32'(obs_rd[i]), match ? 32'(data[8*i +: 8]) : 32'hFF);
        end
        exp_rx = (match && !r) ? n : 0;
        checkOutput({tag, " rx_count"}, 32'(rx_cnt - rx_base), 32'(exp_rx));
        for (int i = 0; i < exp_rx; i++)
            checkOutput({tag, " rx_byte"}, 32'(rx_log[8'(rx_base + i)]), 32'(data[8*i +: 8]));
        if (exp_rx > 0) model_rx = data[8*(exp_rx-1) +: 8];
        checkOutput({tag, " rx_data"}, 32'(rx_data), 32'(model_rx));
        checkOutput({tag, " tx_loads"}, 32'(load_count - ld_base), (match && r) ? 32'(n) : 32'd0);
        if (match) model_rw = r;
        checkOutput({tag, " rw"}, 32'(rw), 32'(model_rw));
        checkOutput({tag, " busy_end"}, 32'(busy), 32'd0);
        if (!match) checkOutput({tag, " no_drive"}, 32'(drive_cnt - drv_base), 32'd0);
        checkOutput({tag, " pulse_width"}, 32'(width_err), 32'd0);
    endtask

    task automatic applyStimulus(input string tag, input logic [6:0] addr, input logic r, input int n,
                                 input logic [31:0] data);
        int rx_base, ld_base, drv_base;
        rx_base   = rx_cnt;
        ld_base   = load_count;
        drv_base  = drive_cnt;
        for (int i = 0; i < 4; i++) tx_bytes[i] = data[8*i +: 8];
        load_base = load_count;
        bus_start();
        txn_body(addr, r, n, data);
        bus_stop();
        wait_clks(8);
        check_txn(tag, addr, r, n, data, rx_base, ld_base, drv_base);
    endtask

    typedef struct {
        logic [6:0]  addr;
        logic        r;
        int          n;
        logic [31:0] data;
        logic        exp_ack;
        int          exp_loads;
    } vec_t;

    vec_t vecs [7];

    initial begin
        logic [7:0] got;
        logic       s;
        int         rx_base, ld_base;
        logic [6:0] ra;

        for (int i = 0; i < 4; i++) tx_bytes[i] = 8'h00;
        vecs[0] = '{7'h27, 1'b0, 1, 32'h000000A5, 1'b0, 0};
        vecs[1] = '{7'h27, 1'b1, 1, 32'h0000003C, 1'b0, 1};
        vecs[2] = '{7'h28, 1'b0, 1, 32'h000000FF, 1'b1, 0};
        vecs[3] = '{7'h27, 1'b1, 2, 32'h00002211, 1'b0, 2};
        vecs[4] = '{7'h27, 1'b0, 3, 32'h005AFF00, 1'b0, 0};
        vecs[5] = '{7'h13, 1'b1, 1, 32'h00000081, 1'b1, 0};
        vecs[6] = '{7'h67, 1'b0, 1, 32'h00000042, 1'b1, 0};

        wait_clks(3);
        checkOutput("reset sda", 32'(sda_bus), 32'd1);
        checkOutput("reset rx_data", 32'(rx_data), 32'h00);
        checkOutput("reset rx_valid", 32'(rx_valid), 32'd0);
        checkOutput("reset tx_load", 32'(tx_load), 32'd0);
        checkOutput("reset rw", 32'(rw), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        rst = 1'b1;
        wait_clks(4);

        for (int v = 0; v < 7; v++) begin
            ld_base = load_count;
            applyStimulus($sformatf("vec%0d", v), vecs[v].addr, vecs[v].r, vecs[v].n, vecs[v].data);
            checkOutput($sformatf("vec%0d tbl_ack", v), 32'(obs_addr_ack), 32'(vecs[v].exp_ack));
            checkOutput($sformatf("vec%0d tbl_loads", v), 32'(load_count - ld_base), 32'(vecs[v].exp_loads));
        end

        // Write one byte, then repeated START into a read without an intervening STOP
        rx_base     = rx_cnt;
        ld_base     = load_count;
        tx_bytes[0] = 8'h9D;
        load_base   = load_count;
        bus_start();
        txn_body(7'h27, 1'b0, 1, 32'h00000001);
        checkOutput("rs rw_write", 32'(rw), 32'd0);
        checkOutput("rs write_ack", 32'(obs_ack[0]), 32'd0);
        bus_start();
        txn_body(7'h27, 1'b1, 1, 32'h0000009D);
        bus_stop();
        wait_clks(8);
        checkOutput("rs rx_data", 32'(rx_data), 32'h01);
        checkOutput("rs rx_count", 32'(rx_cnt - rx_base), 32'd1);
        checkOutput("rs rw_read", 32'(rw), 32'd1);
        checkOutput("rs read_byte", 32'(obs_rd[0]), 32'h9D);
        checkOutput("rs tx_loads", 32'(load_count - ld_base), 32'd1);
        checkOutput("rs busy_end", 32'(busy), 32'd0);
        model_rw = 1'b1;
        model_rx = 8'h01;

        // Reset asserted while the slave is pulling the address ACK low
        bus_start();
        xfer_byte({7'h27, 1'b0}, got);
        m_low = 1'b0;
        #1;
        checkOutput("rst ack_low", 32'(sda_bus), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        checkOutput("rst sda_released", 32'(sda_bus), 32'd1);
        checkOutput("rst rx_data", 32'(rx_data), 32'h00);
        checkOutput("rst rx_valid", 32'(rx_valid), 32'd0);
        checkOutput("rst tx_load", 32'(tx_load), 32'd0);
        checkOutput("rst rw", 32'(rw), 32'd0);
        checkOutput("rst busy", 32'(busy), 32'd0);
        model_rw = 1'b0;
        model_rx = 8'h00;
        wait_clks(3);
        rst = 1'b1;
        wait_clks(2);
        bus_stop();
        wait_clks(4);
        applyStimulus("post_reset", 7'h27, 1'b0, 2, 32'h0000C35A);

        for (int k = 0; k < 20; k++) begin
            ra = ($urandom_range(0, 1) == 1) ? SLAVE_ADDR : 7'($urandom);
            applyStimulus($sformatf("rand%0d", k), ra, 1'($urandom_range(0, 1)),
                          int'($urandom_range(1, 3)), 32'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
